// File: rtl/ps2_receiver_if.sv
// PS/2 receiver bundle: raw pad lines in, received byte and strobes out.
// The master side is the receiver itself; the slave side is whatever drives
// the pads and consumes the bytes.
// state_dbg mirrors the receiver FSM (0=IDLE 1=DATA 2=PARITY 3=STOP).
interface ps2_receiver_if;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] data;
    logic       data_clk;
    logic       err;
    logic [1:0] state_dbg;

    modport master (
        input  ps2_clk,
        input  ps2_dat,
        output data,
        output data_clk,
        output err,
        output state_dbg
    );

    modport slave (
        output ps2_clk,
        output ps2_dat,
        input  data,
        input  data_clk,
        input  err,
        input  state_dbg
    );
endinterface

// File: rtl/ps2_receiver.sv
// PS/2 device->host line receiver.
// Synchronises and deglitches the pad clock, deserialises 11-bit frames
// (start, 8 data LSB first, odd parity, stop) on filtered falling edges and
// emits each good byte with a one-cycle data_clk strobe. Malformed or stalled
// frames produce a one-cycle err strobe instead.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad parity;
// by default the parity bit is captured but not enforced.
// Handshake: data_clk and err are single-cycle, mutually exclusive strobes
// with no back-pressure; data is valid whenever data_clk is high and holds
// its value until the next good frame.
module ps2_receiver #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic           clk,
    input  logic           rst_n,
    ps2_receiver_if.master bus
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // synchronisers
    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    // clock deglitch filter
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    // frame FSM and datapath
    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    sr_q, sr_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    // registered outputs
    logic [7:0]    data_q, data_d;
    logic          data_clk_q, data_clk_d;
    logic          err_q, err_d;

    logic          fall;
    logic          parity_odd;
    logic          parity_ok;

    assign parity_odd = ^{sr_q, par_q};

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = parity_odd;
`else
    // parity bit is still captured; its value simply never blocks a frame
    assign parity_ok = parity_odd | 1'b1;
`endif

    // Next-state logic for synchronisers, filter, frame FSM and outputs
    always_comb begin
        clk_s1_d   = bus.ps2_clk;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = bus.ps2_dat;
        dat_s2_d   = dat_s1_q;

        filt_d     = filt_q;
        fcnt_d     = '0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        data_d     = data_q;
        data_clk_d = 1'b0;
        err_d      = 1'b0;

        // a new clock level is accepted only after FILTER_LEN straight samples
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s2_q;
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end

        fall = filt_q & ~filt_d;

        // inter-edge watchdog only runs while a frame is open
        if (state_q == IDLE || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (fall) begin
            case (state_q)
                IDLE: begin
                    // a high data line here is a stray edge, not a start bit
                    if (!dat_s2_q) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end
                end
                DATA: begin
                    sr_d = {dat_s2_q, sr_q[7:1]};
                    if (cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = STOP;
                end
                STOP: begin
                    if (dat_s2_q && parity_ok) begin
                        data_d     = sr_q;
                        data_clk_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            sr_d    = '0;
            tmo_d   = '0;
        end
    end

    // State registers, all reset asynchronously to the idle-line condition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            sr_q       <= 8'h00;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            data_q     <= 8'h00;
            data_clk_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            data_q     <= data_d;
            data_clk_q <= data_clk_d;
            err_q      <= err_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.data_clk  = data_clk_q;
    assign bus.err       = err_q;
    assign bus.state_dbg = state_q;

endmodule
